// File: rtl/coffee_pkg.sv
// Shared drink codes, phase encoding and per-drink phase duration table for the brew sequencer.
package coffee_pkg;

  localparam logic [2:0] DRINK_NONE       = 3'd0;
  localparam logic [2:0] DRINK_ESPRESSO   = 3'd1;
  localparam logic [2:0] DRINK_AMERICANO  = 3'd2;
  localparam logic [2:0] DRINK_CAPPUCCINO = 3'd3;
  localparam logic [2:0] DRINK_MOCHA      = 3'd4;

  // Phase values are ordered so that "later phase" is simply a larger encoding.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HEAT   = 3'd1,
    ST_WATER  = 3'd2,
    ST_COFFEE = 3'd3,
    ST_MILK   = 3'd4,
    ST_CHOC   = 3'd5,
    ST_DONE   = 3'd6
  } state_t;

  function automatic logic valid_drink(input logic [2:0] drink);
    return (drink >= DRINK_ESPRESSO) && (drink <= DRINK_MOCHA);
  endfunction

  // Phase duration in ticks; zero means the phase is skipped entirely.
  function automatic logic [3:0] dur(input logic [2:0] drink, input state_t ph);
    logic [3:0] d;
    d = 4'd0;
    case (drink)
      DRINK_ESPRESSO: begin
        case (ph)
          ST_HEAT:   d = 4'd2;
          ST_COFFEE: d = 4'd3;
          default:   d = 4'd0;
        endcase
      end
      DRINK_AMERICANO: begin
        case (ph)
          ST_HEAT:   d = 4'd2;
          ST_WATER:  d = 4'd4;
          ST_COFFEE: d = 4'd3;
          default:   d = 4'd0;
        endcase
      end
      DRINK_CAPPUCCINO: begin
        case (ph)
          ST_HEAT:   d = 4'd2;
          ST_COFFEE: d = 4'd3;
          ST_MILK:   d = 4'd3;
          default:   d = 4'd0;
        endcase
      end
      DRINK_MOCHA: begin
        case (ph)
          ST_HEAT:   d = 4'd2;
          ST_COFFEE: d = 4'd2;
          ST_MILK:   d = 4'd2;
          ST_CHOC:   d = 4'd2;
          default:   d = 4'd0;
        endcase
      end
      default: d = 4'd0;
    endcase
    return d;
  endfunction

  // First phase after cur with a nonzero duration, or DONE if none remain.
  function automatic state_t next_phase(input logic [2:0] drink, input state_t cur);
    state_t n;
    n = ST_DONE;
    for (int p = 5; p >= 1; p--) begin
      if ((p > int'(cur)) && (dur(drink, state_t'(p[2:0])) != 4'd0)) n = state_t'(p[2:0]);
    end
    return n;
  endfunction

endpackage

// File: rtl/brew_tick_div.sv
// Tick prescaler: counts 0..TICK_DIV-1 while enabled and pulses tick on the wrap cycle.
module brew_tick_div #(
  parameter int TICK_DIV = 50_000_000,
  parameter int TICK_W   = 26
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam logic [TICK_W-1:0] CNT_MAX = TICK_W'(TICK_DIV - 1);

  logic [TICK_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
    end
  end

  assign tick = en && (cnt == CNT_MAX);

endmodule

// File: rtl/brew_sequencer.sv
// Drink-preparation controller: latches a drink on start and walks its phase sequence to DONE.
// Optional `BREW_CANCEL_EN adds a cancel input that aborts any running sequence back to IDLE.
module brew_sequencer
  import coffee_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int TICK_W   = 26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] c_type,
  input  logic       start,
`ifdef BREW_CANCEL_EN
  input  logic       cancel,
`endif
  output logic       heater,
  output logic       valve_water,
  output logic       valve_coffee,
  output logic       valve_milk,
  output logic       valve_choc,
  output logic       busy,
  output logic       done,
  output logic [2:0] drink
);

  state_t     state;
  state_t     state_nxt;
  logic [2:0] drink_q;
  logic [2:0] ld_drink;
  logic [3:0] pcnt;
  logic       latch;
  logic       tick;
  logic       cancel_req;
  logic       entering;

`ifdef BREW_CANCEL_EN
  assign cancel_req = cancel;
`else
  assign cancel_req = 1'b0;
`endif

  assign latch    = (state == ST_IDLE) && start && valid_drink(c_type);
  assign ld_drink = (state == ST_IDLE) ? c_type : drink_q;
  assign entering = (state_nxt != state) && (state_nxt >= ST_HEAT) && (state_nxt <= ST_CHOC);

  brew_tick_div #(
    .TICK_DIV(TICK_DIV),
    .TICK_W  (TICK_W)
  ) u_tick_div (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (latch),
    .en   (busy),
    .tick (tick)
  );

  // State register together with the latched drink and the per-phase tick counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      drink_q <= DRINK_NONE;
      pcnt    <= 4'd0;
    end else begin
      state   <= state_nxt;
      drink_q <= (state_nxt == ST_IDLE) ? DRINK_NONE : ld_drink;
      if (entering) begin
        pcnt <= dur(ld_drink, state_nxt) - 4'd1;
      end else if (tick && (pcnt != 4'd0)) begin
        pcnt <= pcnt - 4'd1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (latch) state_nxt = next_phase(c_type, ST_IDLE);
      ST_DONE: state_nxt = ST_IDLE;
      default: if (tick && (pcnt == 4'd0)) state_nxt = next_phase(drink_q, state);
    endcase
    if (cancel_req && (state != ST_IDLE)) state_nxt = ST_IDLE;
  end

  // Outputs decode straight from the state flop, so they change only on clock or reset.
  always_comb begin
    heater       = 1'b0;
    valve_water  = 1'b0;
    valve_coffee = 1'b0;
    valve_milk   = 1'b0;
    valve_choc   = 1'b0;
    done         = 1'b0;
    busy         = (state != ST_IDLE);
    drink        = drink_q;
    case (state)
      ST_HEAT:   heater       = 1'b1;
      ST_WATER:  valve_water  = 1'b1;
      ST_COFFEE: valve_coffee = 1'b1;
      ST_MILK:   valve_milk   = 1'b1;
      ST_CHOC:   valve_choc   = 1'b1;
      ST_DONE:   done         = 1'b1;
      default:   ;
    endcase
  end

endmodule

// File: tb/tb_brew_sequencer.sv
// Bench for brew_sequencer with TICK_DIV=4: directed and randomized drinks against a cycle-list model.
module tb_brew_sequencer;

  localparam int TD = 4;
  localparam int W  = 10;

  logic       clk;
  logic       rst_n;
  logic [2:0] c_type;
  logic       start;
  logic       cancel;
  logic       heater;
  logic       valve_water;
  logic       valve_coffee;
  logic       valve_milk;
  logic       valve_choc;
  logic       busy;
  logic       done;
  logic [2:0] drink;

  int checks;
  int errors;
  logic [W-1:0] exp_q[$];

  brew_sequencer #(
    .TICK_DIV(TD),
    .TICK_W  (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .c_type      (c_type),
    .start       (start),
`ifdef BREW_CANCEL_EN
    .cancel      (cancel),
`endif
    .heater      (heater),
    .valve_water (valve_water),
    .valve_coffee(valve_coffee),
    .valve_milk  (valve_milk),
    .valve_choc  (valve_choc),
    .busy        (busy),
    .done        (done),
    .drink       (drink)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] vec(input logic [4:0] oh, input logic b, input logic dn,
                                       input logic [2:0] dr);
    return {oh, b, dn, dr};
  endfunction

  function automatic logic [W-1:0] observed();
    return {heater, valve_water, valve_coffee, valve_milk, valve_choc, busy, done, drink};
  endfunction

  // Reference model: one expected output vector per clock cycle after the latching edge.
  function automatic void push_drink(input logic [2:0] code);
    int d[5];
    logic [4:0] oh;
    case (code)
      3'd1:    d = '{2, 0, 3, 0, 0};
      3'd2:    d = '{2, 4, 3, 0, 0};
      3'd3:    d = '{2, 0, 3, 3, 0};
      3'd4:    d = '{2, 0, 2, 2, 2};
      default: d = '{0, 0, 0, 0, 0};
    endcase
    for (int ph = 0; ph < 5; ph++) begin
      oh = 5'b10000 >> ph;
      for (int c = 0; c < d[ph] * TD; c++) exp_q.push_back(vec(oh, 1'b1, 1'b0, code));
    end
    exp_q.push_back(vec(5'b00000, 1'b1, 1'b1, code));
  endfunction

  function automatic void push_idle(input int n);
    for (int c = 0; c < n; c++) exp_q.push_back('0);
  endfunction

  // Scoreboard comparison
  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Driver: start held for `hold` cycles; optional mid-run c_type change plus start pulse.
  task automatic run(input string tag, input logic [2:0] code, input int hold, input int perturb_at);
    logic [W-1:0] e;
    c_type = code;
    start  = 1'b1;
    for (int i = 0; exp_q.size() > 0; i++) begin
      step();
      e = exp_q.pop_front();
      check(tag, observed(), e);
      if (i + 1 >= hold) start = 1'b0;
      if (i == perturb_at) begin
        c_type = 3'($urandom_range(0, 7));
        start  = 1'b1;
      end else if (i == perturb_at + 1) begin
        start = 1'b0;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    logic [W-1:0] e;
    logic [2:0]   code;
    int           len;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    c_type = 3'd0;
    start  = 1'b0;
    cancel = 1'b0;
    #23;
    check("reset", observed(), '0);
    rst_n = 1'b1;
    step();
    check("post_reset_idle", observed(), '0);

    push_drink(3'd1); push_idle(1);
    run("espresso", 3'd1, 1, -10);
    push_drink(3'd2); push_idle(1);
    run("americano", 3'd2, 1, -10);
    push_drink(3'd4); push_idle(1);
    run("mocha", 3'd4, 2, -10);

    push_idle(50);
    run("none_code", 3'd0, 50, -10);
    push_idle(50);
    run("code_111", 3'd7, 50, -10);

    // Mid-run perturbation during COFFEE of a cappuccino (cycles 8..19)
    push_drink(3'd3); push_idle(1);
    run("midrun", 3'd3, 1, 12);

    // start held through DONE re-brews after one IDLE cycle
    push_drink(3'd1); push_idle(1);
    len = exp_q.size();
    push_drink(3'd1); push_idle(1);
    run("hold_start", 3'd1, len + 1, -10);

    // Asynchronous reset in MILK of a cappuccino
    push_drink(3'd3);
    c_type = 3'd3;
    start  = 1'b1;
    for (int i = 0; i < 24; i++) begin
      step();
      e = exp_q.pop_front();
      check("pre_reset_run", observed(), e);
      start = 1'b0;
    end
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset", observed(), '0);
    exp_q.delete();
    step();
    rst_n = 1'b1;
    step();
    check("after_reset", observed(), '0);

`ifdef BREW_CANCEL_EN
    push_drink(3'd2);
    c_type = 3'd2;
    start  = 1'b1;
    for (int i = 0; i < 11; i++) begin
      step();
      e = exp_q.pop_front();
      check("pre_cancel_run", observed(), e);
      start = 1'b0;
    end
    exp_q.delete();
    cancel = 1'b1;
    start  = 1'b1;
    step();
    check("cancel", observed(), '0);
    cancel = 1'b0;
    start  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("cancel_idle", observed(), '0);
    end
    push_drink(3'd4); push_idle(1);
    run("after_cancel", 3'd4, 1, -10);
`endif

    // Randomized drinks, start widths and mid-run disturbances
    for (int n = 0; n < 16; n++) begin
      code = 3'($urandom_range(0, 7));
      if (code >= 3'd1 && code <= 3'd4) begin
        push_drink(code); push_idle(1);
        len = exp_q.size();
        run("random_drink", code, $urandom_range(1, 3), $urandom_range(4, len - 4));
      end else begin
        push_idle(6);
        run("random_invalid", code, 6, -10);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
